// File: rtl/img_rx_pkg.sv
// Types and constants shared by the laptop image receiver and the coordinate sender.
package img_rx_pkg;

    localparam int          LAPTOP_WIDTH  = 32;
    localparam int          LAPTOP_HEIGHT = 24;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        CSUM   = 2'd2,
        COMMIT = 2'd3
    } rx_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BUSY    = 2'd3;

endpackage

// File: rtl/img_rx_timeout.sv
// Saturating idle-cycle counter: counts while enabled, clear wins over counting.
// expired is high combinationally once the count has reached LIMIT.
module img_rx_timeout #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CW'(LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/uart_img_assembler.sv
// Builds a checksummed frame from the UART byte stream into a shadow buffer and commits it to
// laptop_img; rdy pulses 2 edges after the checksum byte. Busy detector or bad frames are dropped.
module uart_img_assembler
    import img_rx_pkg::*;
#(
    parameter int         IMG_WIDTH      = LAPTOP_WIDTH,
    parameter int         IMG_HEIGHT     = LAPTOP_HEIGHT,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [7:0]                                  rx_byte,
    input  logic                                        rx_valid,
    input  logic                                        detector_busy,
    output logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0]   laptop_img,
    output logic                                        laptop_img_rdy,
    output logic                                        frame_err,
    output logic [1:0]                                  frame_err_code,
    output logic [15:0]                                 frame_count
);

    localparam int                NPIX     = IMG_WIDTH * IMG_HEIGHT;
    localparam int                IDX_W    = $clog2(NPIX + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NPIX - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [IDX_W-1:0] pix_idx;
    logic [7:0]       csum;
    logic [7:0]       shadow [NPIX];

    logic             timer_clear;
    logic             timer_enable;
    logic             timer_expired;
    logic             take_pix;
    logic             do_commit;
    logic             drop;
    logic [1:0]       drop_code;

    img_rx_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte arriving in the cycle the timer expires takes priority over the timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) state_next = RECV;
            end
            RECV: begin
                if (rx_valid) begin
                    if (pix_idx == LAST_IDX) state_next = CSUM;
                end else if (timer_expired) begin
                    state_next = IDLE;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_byte != csum || detector_busy) state_next = IDLE;
                    else                                  state_next = COMMIT;
                end else if (timer_expired) begin
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        take_pix     = (state == RECV) && rx_valid;
        do_commit    = (state == COMMIT);
        timer_enable = (state == RECV) || (state == CSUM);
        timer_clear  = !timer_enable || rx_valid;
        drop         = 1'b0;
        drop_code    = ERR_NONE;
        if (timer_enable && !rx_valid && timer_expired) begin
            drop      = 1'b1;
            drop_code = ERR_TIMEOUT;
        end else if (state == CSUM && rx_valid) begin
            if (rx_byte != csum) begin
                drop      = 1'b1;
                drop_code = ERR_CSUM;
            end else if (detector_busy) begin
                drop      = 1'b1;
                drop_code = ERR_BUSY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_idx        <= '0;
            csum           <= '0;
            laptop_img     <= '0;
            laptop_img_rdy <= 1'b0;
            frame_err      <= 1'b0;
            frame_err_code <= ERR_NONE;
            frame_count    <= '0;
        end else begin
            laptop_img_rdy <= do_commit;
            frame_err      <= drop;
            if (drop) frame_err_code <= drop_code;
            if (state == IDLE) begin
                pix_idx <= '0;
                csum    <= '0;
            end else if (take_pix) begin
                pix_idx <= pix_idx + IDX_W'(1);
                csum    <= csum ^ rx_byte;
            end
            if (do_commit) begin
                frame_count <= frame_count + 16'd1;
                for (int r = 0; r < IMG_HEIGHT; r++) begin
                    for (int c = 0; c < IMG_WIDTH; c++) begin
                        laptop_img[r][c] <= shadow[r*IMG_WIDTH + c];
                    end
                end
            end
        end
    end

    // Shadow contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clock) begin
        if (take_pix) shadow[pix_idx] <= rx_byte;
    end

endmodule

// File: tb/tb_uart_img_assembler.sv
// Directed bench for uart_img_assembler with a 4x3 frame and a 50-cycle timeout.
module tb_uart_img_assembler;
    import img_rx_pkg::*;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int NP  = W * H;
    localparam int TO  = 50;
    localparam int GAP = 11;

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic [7:0]                 rx_byte = 8'h00;
    logic                       rx_valid = 1'b0;
    logic                       detector_busy = 1'b0;
    logic [H-1:0][W-1:0][7:0]   laptop_img;
    logic                       laptop_img_rdy;
    logic                       frame_err;
    logic [1:0]                 frame_err_code;
    logic [15:0]                frame_count;

    int total = 0;
    int bad = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    logic [7:0] fr [NP];

    uart_img_assembler #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .detector_busy  (detector_busy),
        .laptop_img     (laptop_img),
        .laptop_img_rdy (laptop_img_rdy),
        .frame_err      (frame_err),
        .frame_err_code (frame_err_code),
        .frame_count    (frame_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (laptop_img_rdy) rdy_cnt++;
        if (frame_err) err_cnt++;
        if (laptop_img_rdy && frame_err) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic send_body();
        send_byte(8'hA5, GAP);
        for (int i = 0; i < NP; i++) send_byte(fr[i], GAP);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NP; i++) fr[i] = 8'(i);
    endtask

    int r0;
    int e0;
    int n;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_rdy",   32'(laptop_img_rdy), 32'd0);
        check("rst_err",   32'(frame_err),      32'd0);
        check("rst_code",  32'(frame_err_code), 32'd0);
        check("rst_count", 32'(frame_count),    32'd0);
        check("rst_img",   32'(laptop_img[2][3]), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: ramp 00..0B; XOR of 00..0B is 00
        fill_ramp();
        send_body();
        send_byte(8'h00, 0);
        check("t1_lat0", 32'(laptop_img_rdy), 32'd0);
        @(posedge clock); #1;
        check("t1_lat1", 32'(laptop_img_rdy), 32'd1);
        check("t1_p00",  32'(laptop_img[0][0]), 32'h00);
        check("t1_p12",  32'(laptop_img[1][2]), 32'h06);
        check("t1_p23",  32'(laptop_img[2][3]), 32'h0B);
        check("t1_cnt",  32'(frame_count), 32'd1);
        @(posedge clock); #1;
        check("t1_lat2", 32'(laptop_img_rdy), 32'd0);
        repeat (GAP) @(posedge clock);
        #1;
        check("t1_rdys", 32'(rdy_cnt), 32'd1);

        // 2: same pixels, wrong checksum 0B
        r0 = rdy_cnt; e0 = err_cnt;
        send_body();
        send_byte(8'h0B, GAP);
        check("t2_err",  32'(err_cnt - e0), 32'd1);
        check("t2_code", 32'(frame_err_code), 32'(ERR_CSUM));
        check("t2_rdy",  32'(rdy_cnt - r0), 32'd0);
        check("t2_img",  32'(laptop_img[2][3]), 32'h0B);
        check("t2_cnt",  32'(frame_count), 32'd1);

        // 3: stall after 5 pixels; timeout fires 51 edges after the last byte
        e0 = err_cnt;
        send_byte(8'hA5, GAP);
        for (int i = 0; i < 4; i++) send_byte(fr[i], GAP);
        send_byte(fr[4], 0);
        n = 0;
        while (!frame_err && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("t3_lat",  32'(n), 32'(TO + 1));
        check("t3_code", 32'(frame_err_code), 32'(ERR_TIMEOUT));
        repeat (10) @(posedge clock);
        #1;
        check("t3_err",  32'(err_cnt - e0), 32'd1);
        send_body();
        send_byte(8'h00, GAP);
        check("t3_cnt",  32'(frame_count), 32'd2);

        // 4: detector busy at checksum, then retry with it free
        r0 = rdy_cnt; e0 = err_cnt;
        send_body();
        detector_busy = 1'b1;
        send_byte(8'h00, GAP);
        detector_busy = 1'b0;
        check("t4_code", 32'(frame_err_code), 32'(ERR_BUSY));
        check("t4_err",  32'(err_cnt - e0), 32'd1);
        check("t4_rdy",  32'(rdy_cnt - r0), 32'd0);
        check("t4_cnt0", 32'(frame_count), 32'd2);
        send_body();
        send_byte(8'h00, GAP);
        check("t4_cnt1", 32'(frame_count), 32'd3);
        check("t4_rdy1", 32'(rdy_cnt - r0), 32'd1);

        // 5: leading garbage, A5 as pixel data at [0][0] and [1][1]; csum = A5^0^A5^5 = 05
        fill_ramp();
        fr[0] = 8'hA5;
        fr[5] = 8'hA5;
        send_byte(8'h11, GAP);
        send_byte(8'h22, GAP);
        send_body();
        send_byte(8'h05, GAP);
        check("t5_cnt", 32'(frame_count), 32'd4);
        check("t5_p00", 32'(laptop_img[0][0]), 32'hA5);
        check("t5_p11", 32'(laptop_img[1][1]), 32'hA5);
        check("t5_p10", 32'(laptop_img[1][0]), 32'h04);

        // 6: reset after 7 pixels, then a fresh frame of i*3 (csum 34)
        send_byte(8'hA5, GAP);
        for (int i = 0; i < 7; i++) send_byte(fr[i], GAP);
        #3 reset = 1'b1;
        #1;
        check("t6_img",  32'(laptop_img[0][0]), 32'd0);
        check("t6_cnt",  32'(frame_count), 32'd0);
        check("t6_code", 32'(frame_err_code), 32'd0);
        check("t6_rdy",  32'(laptop_img_rdy), 32'd0);
        check("t6_err",  32'(frame_err), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < NP; i++) fr[i] = 8'(i * 3);
        send_body();
        send_byte(8'h34, GAP);
        check("t6_cnt1", 32'(frame_count), 32'd1);
        check("t6_p23",  32'(laptop_img[2][3]), 32'h21);
        check("t6_p11",  32'(laptop_img[1][1]), 32'h0F);
        check("t6_p00",  32'(laptop_img[0][0]), 32'h00);

        check("overlap", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
